// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
//   state_t        : loader FSM state encoding
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   WORD_W         : instruction word width
//   IDX_W/LAST_IDX : byte index within a word and its final value
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int IDX_W          = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-to-word packer with running XOR checksum.
//   clk, rst     : system clock, asynchronous active-low reset
//   clr          : zero word, byte index and checksum
//   shift        : accept byte_in (first byte ends up in the MSBs)
//   byte_in      : stream byte
//   word         : packed word (stable while shift is low)
//   byte_idx     : index of the next byte within the word
//   checksum     : XOR of every byte shifted since the last clear
module imem_loader_word_packer
  import imem_loader_pkg::*;
#(
  parameter int BYTE_W = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               shift,
  input  logic [BYTE_W-1:0]                  byte_in,
  output logic [BYTES_PER_WORD*BYTE_W-1:0]   word,
  output logic [IDX_W-1:0]                   byte_idx,
  output logic [BYTE_W-1:0]                  checksum
);

  localparam int PW = BYTES_PER_WORD * BYTE_W;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word     <= '0;
      byte_idx <= '0;
      checksum <= '0;
    end else if (clr) begin
      word     <= '0;
      byte_idx <= '0;
      checksum <= '0;
    end else if (shift) begin
      word     <= {word[PW-BYTE_W-1:0], byte_in};
      // Index wraps 3 -> 0 naturally, ready for the next word.
      byte_idx <= byte_idx + 1'b1;
      checksum <= checksum ^ byte_in;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: receives COUNT, 4*N data bytes (MSB first) and an
// XOR checksum byte, writes the packed words into instruction memory and keeps
// the processor in reset until a verified image is present.
//   clk, rst    : system clock, asynchronous active-low reset
//   start       : begin a load (accepted in IDLE/DONE/ERR only)
//   in_valid/in_data/in_ready : byte stream handshake
//   imem_we/imem_addr/imem_wdata : instruction-memory write port
//   cpu_hold    : processor reset request, low only in DONE
//   done, err   : load status levels
//   words_left  : words still expected in the current frame
//
// state | meaning
// IDLE  | after reset, waiting for start
// COUNT | expecting the word-count byte
// DATA  | collecting instruction bytes
// WRITE | one-cycle write of the packed word (stream stalled)
// CHECK | expecting the checksum byte
// DONE  | image verified, processor released
// ERR   | bad count or checksum, processor held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int BYTE_W = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  input  logic [BYTE_W-1:0]                in_data,
  output logic                             in_ready,
  output logic                             imem_we,
  output logic [ADDR_W-1:0]                imem_addr,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] imem_wdata,
  output logic                             cpu_hold,
  output logic                             done,
  output logic                             err,
  output logic [ADDR_W:0]                  words_left
);

  localparam int MAX_WORDS = 1 << ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     addr_q;
  logic [ADDR_W:0]     words_left_q;
  logic                imem_we_q;
  logic                xfer;
  logic                count_ok;
  logic                pk_clr, pk_shift;
  logic [IDX_W-1:0]    pk_idx;
  logic [BYTE_W-1:0]   pk_sum;

  imem_loader_word_packer #(.BYTE_W(BYTE_W)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .shift    (pk_shift),
    .byte_in  (in_data),
    .word     (imem_wdata),
    .byte_idx (pk_idx),
    .checksum (pk_sum)
  );

  assign in_ready = (state_q == ST_COUNT) || (state_q == ST_DATA) ||
                    (state_q == ST_CHECK);
  assign xfer     = in_valid && in_ready;
  assign count_ok = (in_data != '0) && (int'(in_data) <= MAX_WORDS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pk_clr   = 1'b0;
    pk_shift = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_COUNT;
          pk_clr  = 1'b1;
        end
      end
      ST_COUNT: begin
        if (xfer) begin
          state_d = count_ok ? ST_DATA : ST_ERR;
          pk_clr  = 1'b1;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          pk_shift = 1'b1;
          if (pk_idx == LAST_IDX) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = (words_left_q == (ADDR_W+1)'(1)) ? ST_CHECK : ST_DATA;
      end
      ST_CHECK: begin
        if (xfer) state_d = (in_data == pk_sum) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      words_left_q <= '0;
      imem_we_q    <= 1'b0;
    end else begin
      // Registered strobe aligned with the WRITE state; the top address bit
      // guards against ever writing past the end of memory.
      imem_we_q <= (state_d == ST_WRITE) && !addr_q[ADDR_W];
      if (state_q == ST_COUNT && xfer && count_ok) begin
        words_left_q <= (ADDR_W+1)'(in_data);
        addr_q       <= '0;
      end else if (state_q == ST_WRITE) begin
        words_left_q <= words_left_q - 1'b1;
        addr_q       <= addr_q + 1'b1;
      end
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = addr_q[ADDR_W-1:0];
  assign words_left = words_left_q;
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign cpu_hold   = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [ADDR_W:0] words_left;

  imem_loader #(.ADDR_W(ADDR_W), .BYTE_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .words_left (words_left)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] img [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(32'(imem_addr));
      wr_data_q.push_back(imem_wdata);
    end
  end

  function automatic logic [7:0] img_xor(input int n);
    logic [7:0] x = 8'h00;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = img[i];
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    return x;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int guard;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'hA5;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("xfer_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'hA5;
  endtask

  // Sends count, n words from img, then checksum byte. If start_at >= 0 a
  // start pulse is issued just before data byte number start_at.
  task automatic send_frame(input int n, input logic [7:0] chk_byte,
                            input int max_gap, input int start_at);
    logic [31:0] w;
    send_byte(8'(n), max_gap);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        if (start_at == i*4 + k) pulse_start();
        send_byte(w[31-8*k -: 8], max_gap);
      end
    end
    send_byte(chk_byte, max_gap);
  endtask

  task automatic check_writes(input string tag, input int n);
    chk($sformatf("%s_nwr", tag), 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], 32'(i));
      chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], img[i]);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  initial begin
    logic [31:0] w;

    // 1. reset values
    #23;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_we", 32'(imem_we), 32'd0);
    chk("idle_addr", 32'(imem_addr), 32'd0);
    chk("idle_wdata", imem_wdata, 32'd0);
    chk("idle_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_err", 32'(err), 32'd0);
    chk("idle_words_left", 32'(words_left), 32'd0);

    // 2. two-word frame; XOR of the eight bytes is 0x55
    img[0] = 32'h20080005;
    img[1] = 32'h01095020;
    chk("t2_xor_model", 32'(img_xor(2)), 32'h55);
    pulse_start();
    chk("t2_count_ready", 32'(in_ready), 32'd1);
    send_byte(8'd2, 0);
    chk("t2_words_left", 32'(words_left), 32'd2);
    w = img[0];
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], 0);
    chk("t2_we_latency", 32'(imem_we), 32'd1);
    chk("t2_bubble", 32'(in_ready), 32'd0);
    chk("t2_wdata0", imem_wdata, 32'h20080005);
    w = img[1];
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], 0);
    send_byte(8'h55, 0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_words_left_end", 32'(words_left), 32'd0);
    check_writes("t2", 2);

    // 3. bad checksum, then recovery
    pulse_start();
    chk("t3_reload_hold", 32'(cpu_hold), 32'd1);
    chk("t3_reload_done", 32'(done), 32'd0);
    send_frame(2, 8'h00, 0, -1);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    check_writes("t3_bad", 2);
    pulse_start();
    chk("t3_err_clr", 32'(err), 32'd0);
    send_frame(2, 8'h55, 0, -1);
    chk("t3_recover_done", 32'(done), 32'd1);
    chk("t3_recover_hold", 32'(cpu_hold), 32'd0);
    check_writes("t3_good", 2);

    // 4. out-of-range counts
    pulse_start();
    send_byte(8'd0, 0);
    chk("t4_n0_err", 32'(err), 32'd1);
    chk("t4_n0_ready", 32'(in_ready), 32'd0);
    pulse_start();
    send_byte(8'd17, 0);
    chk("t4_n17_err", 32'(err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    check_writes("t4", 0);

    // 5. full memory with random valid gaps
    for (int i = 0; i < 16; i++) img[i] = $urandom;
    pulse_start();
    send_frame(16, img_xor(16), 3, -1);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_words_left", 32'(words_left), 32'd0);
    check_writes("t5", 16);

    // 6. reset mid-frame, then a load with a start pulse mid-DATA
    img[0] = 32'hDEADBEEF;
    img[1] = 32'h00C0FFEE;
    img[2] = 32'h12345678;
    pulse_start();
    send_byte(8'd3, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    rst = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_hold", 32'(cpu_hold), 32'd1);
    chk("t6_rst_words_left", 32'(words_left), 32'd0);
    chk("t6_rst_wdata", imem_wdata, 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_writes("t6_rst", 0);
    pulse_start();
    send_frame(3, img_xor(3), 1, 6);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_cpu_hold", 32'(cpu_hold), 32'd0);
    check_writes("t6", 3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
